// File: rtl/program_loader.sv
// program_loader: boot-time loader for the single-cycle MIPS CPU instruction
// memory. Packs a big-endian byte stream into 32-bit words, writes them to
// consecutive word addresses, then releases the CPU via cpu_run.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (final word of the image
// is a mod-2^32 checksum of all preceding words and is not written).
module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [31:0]       imem_a,
    output logic [31:0]       imem_wd,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count,
    output logic              error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    // One past the last addressable word: accepting a full word here overflows.
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]      state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [ADDR_W:0] word_idx_q, word_idx_d;
    logic [31:0]     word_q, word_d;
    logic            last_q, last_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]     sum_q, sum_d;
`endif

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        last_d     = last_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_RECV;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    word_d     = '0;
                    last_d     = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            S_RECV: begin
                // in_ready is 1 throughout RECV, so in_valid alone means accept.
                if (in_valid) begin
                    if (byte_idx_q == 2'd3) begin
                        if (word_idx_q == CAP) begin
                            state_d = S_ERR;
                        end else begin
                            word_d[7:0] = in_data;
                            last_d      = in_last;
                            state_d     = S_WRITE;
                        end
                    end else if (in_last) begin
                        state_d = S_ERR;
                    end else begin
                        case (byte_idx_q)
                            2'd0:    word_d[31:24] = in_data;
                            2'd1:    word_d[23:16] = in_data;
                            default: word_d[15:8]  = in_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                byte_idx_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (last_q) begin
                    state_d = (word_q == sum_q) ? S_DONE : S_ERR;
                end else begin
                    word_idx_d = word_idx_q + (ADDR_W+1)'(1);
                    sum_d      = sum_q + word_q;
                    state_d    = S_RECV;
                end
`else
                word_idx_d = word_idx_q + (ADDR_W+1)'(1);
                state_d    = last_q ? S_DONE : S_RECV;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset discards any partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            word_q     <= word_d;
            last_q     <= last_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        imem_a                = '0;
        imem_a[ADDR_W+2:2]    = word_idx_q;
    end

    assign in_ready   = (state_q == S_RECV);
    assign cpu_run    = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign imem_wd    = word_q;
    assign word_count = word_idx_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // The checksum word occupies a WRITE cycle but is never stored.
    assign imem_we    = (state_q == S_WRITE) && !last_q;
`else
    assign imem_we    = (state_q == S_WRITE);
`endif

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed and randomized image loads checked
// against a word-level reference model of the loader's outcome.
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        in_ready_a, imem_we_a, cpu_run_a, error_a;
    logic [31:0] imem_a_a, imem_wd_a;
    logic [10:0] word_count_a;
    logic        in_ready_b, imem_we_b, cpu_run_b, error_b;
    logic [31:0] imem_a_b, imem_wd_b;
    logic [2:0]  word_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we_a), .imem_a(imem_a_a), .imem_wd(imem_wd_a),
        .cpu_run(cpu_run_a), .word_count(word_count_a), .error(error_a)
    );

    program_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we_b), .imem_a(imem_a_b), .imem_wd(imem_wd_b),
        .cpu_run(cpu_run_b), .word_count(word_count_b), .error(error_b)
    );

    // Observed memory writes and cpu_run timing, per DUT.
    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];
    int cyc = 0;
    int last_we_a = -2, rise_a = -1, last_we_b = -2, rise_b = -1;
    logic prev_run_a = 1'b0, prev_run_b = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (start_a) begin wq_a.delete(); last_we_a = -2; rise_a = -1; end
        if (start_b) begin wq_b.delete(); last_we_b = -2; rise_b = -1; end
        if (imem_we_a) begin wq_a.push_back({imem_a_a, imem_wd_a}); last_we_a = cyc; end
        if (imem_we_b) begin wq_b.push_back({imem_a_b, imem_wd_b}); last_we_b = cyc; end
        if (cpu_run_a && !prev_run_a) rise_a = cyc;
        if (cpu_run_b && !prev_run_b) rise_b = cyc;
        prev_run_a = cpu_run_a;
        prev_run_b = cpu_run_b;
    end

    // Stimulus image and expected outcome.
    logic [7:0]  tx_q[$];
    logic [63:0] exp_q[$];
    bit          exp_err;
    bit          exp_timed;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    // Reference: whole words land at consecutive addresses until the image
    // ends cleanly, is truncated, overflows capacity, or fails its checksum.
    task automatic run_model(input int cap);
        int n;
        int nfull;
        bit trunc;
        logic [31:0] sum;
        logic [31:0] w;
        n = tx_q.size();
        nfull = n / 4;
        trunc = (n % 4) != 0;
        sum = '0;
        exp_q.delete();
        exp_err = 1'b1;
        exp_timed = 1'b0;
        for (int k = 0; k < nfull; k++) begin
            w = {tx_q[4*k], tx_q[4*k+1], tx_q[4*k+2], tx_q[4*k+3]};
            if (k == cap) return;
            if (CK && !trunc && k == nfull - 1) begin
                exp_err = (w != sum);
                return;
            end
            exp_q.push_back({32'(k * 4), w});
            sum = sum + w;
        end
        if (!trunc) begin
            exp_err = 1'b0;
            exp_timed = 1'b1;
        end
    endtask

    task automatic do_start(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Streams tx_q; a byte counts as consumed only when valid meets ready.
    task automatic send(input bit sel, input bit mark_last, input bit gaps);
        int idx;
        int budget;
        int n;
        bit v;
        bit rdy;
        idx = 0;
        n = tx_q.size();
        budget = 8 * n + 40;
        while (idx < n && budget > 0) begin
            @(negedge clk);
            budget--;
            rdy = sel ? in_ready_b : in_ready_a;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = v ? tx_q[idx] : 8'($urandom);
            in_last  = v ? (mark_last && idx == n - 1) : 1'($urandom);
            if (v && rdy) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bytes_consumed", 64'(idx), 64'(n));
    endtask

    task automatic check_load(input bit sel);
        logic [63:0] got[$];
        int rise;
        int lwe;
        repeat (3) @(negedge clk);
        if (sel) begin
            got = wq_b;
            rise = rise_b;
            lwe = last_we_b;
            chk("error", 64'(error_b), 64'(exp_err));
            chk("cpu_run", 64'(cpu_run_b), 64'(!exp_err));
            chk("word_count", 64'(word_count_b), 64'(exp_q.size()));
            chk("in_ready_idle", 64'(in_ready_b), 64'd0);
        end else begin
            got = wq_a;
            rise = rise_a;
            lwe = last_we_a;
            chk("error", 64'(error_a), 64'(exp_err));
            chk("cpu_run", 64'(cpu_run_a), 64'(!exp_err));
            chk("word_count", 64'(word_count_a), 64'(exp_q.size()));
            chk("in_ready_idle", 64'(in_ready_a), 64'd0);
        end
        chk("num_writes", 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk("write_addr_data", got[i], exp_q[i]);
        if (exp_timed) chk("run_latency", 64'(rise), 64'(lwe + 1));
    endtask

    task automatic chk_reset_a();
        chk("rst_in_ready", 64'(in_ready_a), 64'd0);
        chk("rst_imem_we", 64'(imem_we_a), 64'd0);
        chk("rst_imem_a", 64'(imem_a_a), 64'd0);
        chk("rst_imem_wd", 64'(imem_wd_a), 64'd0);
        chk("rst_cpu_run", 64'(cpu_run_a), 64'd0);
        chk("rst_word_count", 64'(word_count_a), 64'd0);
        chk("rst_error", 64'(error_a), 64'd0);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] w;
        int nw;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        #3;
        chk_reset_a();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_a();

        // Truncated first word: in_last on byte 3 of 4.
        tx_q = '{8'h20, 8'h08, 8'h00};
        run_model(1024);
        do_start(0);
        send(0, 1, 0);
        check_load(0);
        do_start(0);
        chk("restart_error", 64'(error_a), 64'd0);
        chk("restart_in_ready", 64'(in_ready_a), 64'd1);

        // Two-word image, loaded on the restart above.
        tx_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        run_model(1024);
        send(0, 1, 0);
        check_load(0);

        // Capacity overflow on the small instance.
        tx_q.delete();
        for (int k = 0; k < 5; k++) push_word($urandom);
        run_model(4);
        do_start(1);
        send(1, 1, 0);
        check_load(1);

        // Reset mid-way through the second word.
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_start(0);
        send(0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_a();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a WRITE is in progress.
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_start(0);
        send(0, 0, 0);
        chk("write_cycle_we", 64'(imem_we_a), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("reset_drops_we", 64'(imem_we_a), 64'd0);
        chk("reset_word_count", 64'(word_count_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh single-word load after reset.
        tx_q.delete();
        push_word($urandom);
        run_model(1024);
        do_start(0);
        send(0, 1, 0);
        check_load(0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        tx_q.delete();
        push_word(32'h0000_0001); push_word(32'hFFFF_FFFF); push_word(32'h0000_0000);
        run_model(1024);
        do_start(0);
        send(0, 1, 0);
        check_load(0);
        tx_q.delete();
        push_word(32'h0000_0001); push_word(32'hFFFF_FFFF); push_word(32'h0000_0001);
        run_model(1024);
        do_start(0);
        send(0, 1, 0);
        check_load(0);
        tx_q.delete();
        push_word(32'h0000_0000);
        run_model(1024);
        do_start(0);
        send(0, 1, 0);
        check_load(0);
`endif

        // Random images, each loaded gap-free and then with random valid gaps.
        for (int it = 0; it < 5; it++) begin
            s = '0;
            nw = $urandom_range(1, 6);
            tx_q.delete();
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                if (k == nw - 1 && $urandom_range(0, 1) == 1) w = s;
                s = s + w;
                push_word(w);
            end
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) void'(tx_q.pop_back());
            run_model(1024);
            do_start(0);
            send(0, 1, 0);
            check_load(0);
            do_start(0);
            send(0, 1, 1);
            check_load(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
